// File: rtl/irst_controller_pkg.sv
// Shared state encodings, pattern codes, command-word fields and LFSR helper for the
// register-file self-test sequencer.
package irst_controller_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StClear,
        StDone,
        StWaitClr
    } irst_state_e;

    localparam logic [2:0] PatZero = 3'b000;
    localparam logic [2:0] PatWalk = 3'b001;
    localparam logic [2:0] PatLfsr = 3'b010;
    localparam logic [2:0] PatChk  = 3'b011;

    localparam int unsigned CmdStartBit = 15;
    localparam int unsigned CmdPatMsb   = 14;
    localparam int unsigned CmdPatLsb   = 12;
    localparam int unsigned CmdCountMsb = 11;

    // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/irst_controller_pattern_gen.sv
// Test-pattern generator: combinational pattern(pass, reg, mode) plus the LFSR with a
// per-pass seed copy so the read phase regenerates the write phase's sequence.
module irst_controller_pattern_gen
    import irst_controller_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_step,
    input  logic        i_save,
    input  logic        i_restore,
    input  logic [2:0]  i_mode,
    input  logic [3:0]  i_pass,
    input  logic [2:0]  i_reg,
    output logic [15:0] o_pattern
);

    logic [15:0] r_lfsr;
    logic [15:0] r_seed;
    logic [3:0]  w_walk_sh;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= LFSR_SEED;
            r_seed <= LFSR_SEED;
        end else if (i_start) begin
            r_lfsr <= LFSR_SEED;
            r_seed <= LFSR_SEED;
        end else begin
            if (i_save) begin
                r_seed <= r_lfsr;
            end
            // Restore on the last write word so the first read sees the pass seed.
            if (i_restore) begin
                r_lfsr <= r_seed;
            end else if (i_step) begin
                r_lfsr <= lfsr_step(r_lfsr);
            end
        end
    end

    assign w_walk_sh = i_pass + {1'b0, i_reg};

    always_comb begin
        o_pattern = 16'h0000;
        case (i_mode)
            PatWalk: o_pattern = 16'h0001 << w_walk_sh;
            PatLfsr: o_pattern = r_lfsr;
            PatChk:  o_pattern = (i_pass[0] ^ i_reg[0]) ? 16'hAAAA : 16'h5555;
            default: o_pattern = 16'h0000;
        endcase
    end

endmodule

// File: rtl/irst_controller.sv
// Register-file self-test sequencer: write/read-compare passes over R1..R7, then zero-clear.
// Optional IRST_ABORT_ON_FAIL_EN: first mismatch cuts READ short and jumps to CLEAR.
module irst_controller
    import irst_controller_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_irst_reg_data,
    input  logic [15:0] i_irst_rd_data,
    output logic        o_irst_busy,
    output logic        o_irst_wr_en,
    output logic [2:0]  o_irst_wr_dest,
    output logic [15:0] o_irst_wr_data,
    output logic [2:0]  o_irst_rd_addr,
    output logic        o_irst_done,
    output logic        o_irst_fail,
    output logic [2:0]  o_irst_fail_reg
);

    localparam logic [2:0] RegFirst = 3'(FIRST_REG);
    localparam logic [2:0] RegLast  = 3'(LAST_REG);

    irst_state_e r_state, w_state_next;
    logic [2:0]  r_reg, w_reg_next;
    logic [11:0] r_pass, w_pass_next;
    logic [11:0] r_count, w_count_next;
    logic [2:0]  r_mode, w_mode_next;
    logic        r_fail, w_fail_next;
    logic [2:0]  r_fail_reg, w_fail_reg_next;

    logic [15:0] w_pattern;
    logic        w_start;
    logic        w_last_reg;
    logic        w_mismatch;

    assign w_start    = (r_state == StIdle) && i_irst_reg_data[CmdStartBit];
    assign w_last_reg = (r_reg == RegLast);
    assign w_mismatch = (r_state == StRead) && (i_irst_rd_data != w_pattern);

    irst_controller_pattern_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (w_start),
        .i_step    ((r_state == StWrite) || (r_state == StRead)),
        .i_save    ((r_state == StWrite) && (r_reg == RegFirst)),
        .i_restore ((r_state == StWrite) && w_last_reg),
        .i_mode    (r_mode),
        .i_pass    (r_pass[3:0]),
        .i_reg     (r_reg),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_reg      <= 3'd0;
            r_pass     <= 12'd0;
            r_count    <= 12'd0;
            r_mode     <= PatZero;
            r_fail     <= 1'b0;
            r_fail_reg <= 3'd0;
        end else begin
            r_state    <= w_state_next;
            r_reg      <= w_reg_next;
            r_pass     <= w_pass_next;
            r_count    <= w_count_next;
            r_mode     <= w_mode_next;
            r_fail     <= w_fail_next;
            r_fail_reg <= w_fail_reg_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_reg_next      = r_reg;
        w_pass_next     = r_pass;
        w_count_next    = r_count;
        w_mode_next     = r_mode;
        w_fail_next     = r_fail;
        w_fail_reg_next = r_fail_reg;
        o_irst_busy     = 1'b0;
        o_irst_wr_en    = 1'b0;
        o_irst_wr_dest  = 3'd0;
        o_irst_wr_data  = 16'h0000;
        o_irst_rd_addr  = 3'd0;
        o_irst_done     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next    = StWrite;
                    w_reg_next      = RegFirst;
                    w_pass_next     = 12'd0;
                    w_count_next    = i_irst_reg_data[CmdCountMsb:0];
                    w_mode_next     = i_irst_reg_data[CmdPatMsb:CmdPatLsb];
                    w_fail_next     = 1'b0;
                    w_fail_reg_next = 3'd0;
                end
            end
            StWrite: begin
                o_irst_busy    = 1'b1;
                o_irst_wr_en   = 1'b1;
                o_irst_wr_dest = r_reg;
                o_irst_wr_data = w_pattern;
                if (w_last_reg) begin
                    w_reg_next   = RegFirst;
                    w_state_next = StRead;
                end else begin
                    w_reg_next = r_reg + 3'd1;
                end
            end
            StRead: begin
                o_irst_busy    = 1'b1;
                o_irst_rd_addr = r_reg;
                if (w_mismatch) begin
                    w_fail_next = 1'b1;
                    if (!r_fail) begin
                        w_fail_reg_next = r_reg;
                    end
                end
`ifdef IRST_ABORT_ON_FAIL_EN
                if (w_mismatch) begin
                    w_reg_next   = RegFirst;
                    w_state_next = StClear;
                end else
`endif
                if (w_last_reg) begin
                    w_reg_next = RegFirst;
                    if (r_pass == r_count) begin
                        w_state_next = StClear;
                    end else begin
                        w_pass_next  = r_pass + 12'd1;
                        w_state_next = StWrite;
                    end
                end else begin
                    w_reg_next = r_reg + 3'd1;
                end
            end
            StClear: begin
                o_irst_busy    = 1'b1;
                o_irst_wr_en   = 1'b1;
                o_irst_wr_dest = r_reg;
                if (w_last_reg) begin
                    w_state_next = StDone;
                end else begin
                    w_reg_next = r_reg + 3'd1;
                end
            end
            StDone: begin
                o_irst_busy  = 1'b1;
                o_irst_done  = 1'b1;
                w_state_next = StWaitClr;
            end
            StWaitClr: begin
                // Hold off until R0 bit 15 drops so a stale command cannot restart the run.
                if (!i_irst_reg_data[CmdStartBit]) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_irst_fail     = r_fail;
    assign o_irst_fail_reg = r_fail_reg;

endmodule

// File: tb/tb_irst_controller.sv
// Directed bench for irst_controller with a behavioural register file and an optional
// stuck-at-0 fault on R5 bit 3.
module tb_irst_controller;

`ifdef IRST_ABORT_ON_FAIL_EN
    localparam int InjDone = 21;
    localparam int InjClr  = 14;
`else
    localparam int InjDone = 23;
    localparam int InjClr  = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] reg_data;
    logic [15:0] rd_data;
    logic        busy, wr_en, done, fail;
    logic [2:0]  wr_dest, rd_addr, fail_reg;
    logic [15:0] wr_data;

    logic [15:0] rf [8];
    bit          fill_junk;
    bit          inject;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] wr_log [$];
    int          clr_cyc, rd5_cyc;

    irst_controller u_dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_irst_reg_data (reg_data),
        .i_irst_rd_data  (rd_data),
        .o_irst_busy     (busy),
        .o_irst_wr_en    (wr_en),
        .o_irst_wr_dest  (wr_dest),
        .o_irst_wr_data  (wr_data),
        .o_irst_rd_addr  (rd_addr),
        .o_irst_done     (done),
        .o_irst_fail     (fail),
        .o_irst_fail_reg (fail_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_junk) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'hDEAD;
        end else if (wr_en) begin
            rf[wr_dest] <= wr_data;
        end
    end

    assign rd_data = rf[rd_addr] & ((inject && rd_addr == 3'd5) ? 16'hFFF7 : 16'hFFFF);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {3'b000, busy, wr_en, wr_dest, wr_data, rd_addr, done, fail, fail_reg};
    endfunction

    task automatic check_regs_zero(input string name);
        for (int i = 1; i < 8; i++) begin
            check_eq($sformatf("%s_R%0d", name, i), {16'h0, rf[i]}, 32'h0);
        end
    endtask

    // Cycle 1 is the IDLE cycle in which the start bit is first seen.
    task automatic run_cmd(input logic [15:0] cmd, input bit auto_clr, input int exp_done,
                           input string name);
        int c;
        int busy_cnt;
        int overlap;
        bit seen;
        seen = 0; busy_cnt = 0; overlap = 0; clr_cyc = 0; rd5_cyc = 0;
        wr_log.delete();
        @(negedge clk);
        reg_data = cmd;
        c = 1;
        for (int k = 0; k < 70000 && !seen; k++) begin
            if (busy) busy_cnt++;
            if (wr_en) begin
                wr_log.push_back({wr_dest, wr_data});
                if (wr_data == 16'h0 && clr_cyc == 0) clr_cyc = c;
            end
            if (rd_addr == 3'd5 && rd5_cyc == 0) rd5_cyc = c;
            if (wr_en && rd_addr != 3'd0) overlap++;
            if (done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        check_eq({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check_eq({name, "_done_cyc"}, c, exp_done);
        check_eq({name, "_busy_cycles"}, busy_cnt, exp_done - 1);
        check_eq({name, "_wr_rd_overlap"}, overlap, 32'd0);
        if (auto_clr) reg_data = 16'h0000;
        @(posedge clk);
        #1;
        check_eq({name, "_post_busy_done"}, {30'b0, busy, done}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] walk_exp [7];
        int          busy_cnt;
        int          c;
        walk_exp = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};

        rst = 1'b1; reg_data = 16'h0000; fill_junk = 1; inject = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", outs_vec(), 32'h0);
        rst = 1'b0;
        fill_junk = 0;
        @(posedge clk);
        #1;

        // Zero pattern, single pass, over junk register contents.
        run_cmd(16'h9000, 1, 23, "zero");
        check_eq("zero_fail", {29'b0, fail, fail_reg}, 32'h0);
        check_eq("zero_nwrites", wr_log.size(), 32'd14);
        check_regs_zero("zero");

        // Walking one, two passes.
        run_cmd(16'h9001, 1, 37, "walk");
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("walk_p0_w%0d", i), {13'b0, wr_log[i]},
                     {13'b0, 3'(i + 1), walk_exp[i]});
        end
        check_eq("walk_p1_R1", {13'b0, wr_log[7]}, {13'b0, 3'd1, 16'h0004});
        check_eq("walk_nwrites", wr_log.size(), 32'd21);
        check_eq("walk_fail", {29'b0, fail, fail_reg}, 32'h0);

        // LFSR, three passes.
        run_cmd(16'hA002, 1, 51, "lfsr");
        check_eq("lfsr_w0", {13'b0, wr_log[0]}, {13'b0, 3'd1, 16'hACE1});
        check_eq("lfsr_w1", {13'b0, wr_log[1]}, {13'b0, 3'd2, 16'hE270});
        check_eq("lfsr_nwrites", wr_log.size(), 32'd28);
        check_eq("lfsr_fail", {29'b0, fail, fail_reg}, 32'h0);
        check_regs_zero("lfsr");

        // Checkerboard with R5 bit 3 stuck at 0.
        inject = 1;
        run_cmd(16'hB000, 1, InjDone, "inj");
        check_eq("inj_fail", {31'b0, fail}, 32'd1);
        check_eq("inj_fail_reg", {29'b0, fail_reg}, 32'd5);
        check_eq("inj_rd5_cyc", rd5_cyc, 32'd13);
        check_eq("inj_clr_cyc", clr_cyc, InjClr);
        inject = 0;

        // Start bit held high after done: no restart; fail cleared by the new start.
        run_cmd(16'h9000, 0, 23, "hold");
        check_eq("hold_fail_cleared", {29'b0, fail, fail_reg}, 32'h0);
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (busy || done) busy_cnt++;
        end
        check_eq("hold_no_restart", busy_cnt, 32'd0);
        reg_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        // Reset during the pass-1 READ phase.
        @(negedge clk);
        reg_data = 16'h9001;
        c = 1;
        for (int k = 0; k < 100 && c < 25; k++) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("mid_rd_addr", {29'b0, rd_addr}, 32'd3);
        rst = 1'b1;
        reg_data = 16'h0000;
        @(posedge clk);
        #1;
        check_eq("mid_reset_outputs", outs_vec(), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_idle_outputs", outs_vec(), 32'h0);

        run_cmd(16'h9000, 1, 23, "after_rst");
        check_regs_zero("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
